// File: rtl/move_ctr_fsm.sv
// move_ctr_fsm: turns held left/right/jump keys into a clamped 12-bit on-screen character position
//   clk   in   pixel clock
//   rst   in   asynchronous active-high reset
//   key_a in   held-left level
//   key_d in   held-right level
//   key_w in   held-jump level
//   pos_x out  character x, registered
//   pos_y out  character y, registered, smaller is higher on screen
module move_ctr_fsm #(
    parameter int STEP_DIV = 65_000,
    parameter int X_START  = 512,
    parameter int X_MIN    = 0,
    parameter int X_MAX    = 992,
    parameter int H_STEP   = 2,
    parameter int GROUND_Y = 600,
    parameter int JUMP_V   = 12,
    parameter int GRAVITY  = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        key_a,
    input  logic        key_d,
    input  logic        key_w,
    output logic [11:0] pos_x,
    output logic [11:0] pos_y
);
    localparam int CW = STEP_DIV > 1 ? $clog2(STEP_DIV) : 1;

    typedef enum logic [1:0] {GROUND, RISE, FALL} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [11:0]   x_q, x_d, y_q, y_d;
    logic [7:0]    vy_q, vy_d, vy_rise, vy_fall;
    logic [12:0]   x_r, y_dn;
    logic          tick, land;

    assign pos_x = x_q;
    assign pos_y = y_q;

    always_comb begin
        tick  = cnt_q == CW'(STEP_DIV - 1);
        cnt_d = tick ? '0 : cnt_q + CW'(1);
        x_r   = {1'b0, x_q} + 13'(H_STEP);
        x_d   = x_q;
        if (tick && key_d && !key_a)
            x_d = x_r > 13'(X_MAX) ? 12'(X_MAX) : x_r[11:0];
        else if (tick && key_a && !key_d)
            x_d = {1'b0, x_q} < 13'(X_MIN + H_STEP) ? 12'(X_MIN) : x_q - 12'(H_STEP);
    end

    // vertical FSM: velocity is a magnitude, direction comes from the state
    always_comb begin
        state_d = state_q;
        y_d     = y_q;
        vy_d    = vy_q;
        vy_rise = vy_q - 8'(GRAVITY);
        vy_fall = vy_q + 8'(GRAVITY);
        y_dn    = {1'b0, y_q} + {5'b0, vy_fall};
        land    = y_dn >= 13'(GROUND_Y);
        if (tick) begin
            case (state_q)
                GROUND: if (key_w) begin
                    y_d     = y_q - 12'(JUMP_V);
                    vy_d    = 8'(JUMP_V - GRAVITY);
                    state_d = JUMP_V == GRAVITY ? FALL : RISE;
                end
                RISE: begin
                    y_d     = y_q - {4'b0, vy_q};
                    vy_d    = vy_rise;
                    state_d = vy_rise == 8'd0 ? FALL : RISE;
                end
                FALL: begin
                    y_d     = land ? 12'(GROUND_Y) : y_dn[11:0];
                    vy_d    = land ? 8'd0 : vy_fall;
                    state_d = land ? GROUND : FALL;
                end
                default: state_d = GROUND;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= GROUND;
            cnt_q   <= '0;
            x_q     <= 12'(X_START);
            y_q     <= 12'(GROUND_Y);
            vy_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            x_q     <= x_d;
            y_q     <= y_d;
            vy_q    <= vy_d;
        end
    end
endmodule

// File: tb/tb_move_ctr_fsm.sv
// tb_move_ctr_fsm: directed self-checking bench for move_ctr_fsm with a short tick period
module tb_move_ctr_fsm;
    localparam int DIV = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        key_a = 1'b0;
    logic        key_d = 1'b0;
    logic        key_w = 1'b0;
    logic [11:0] pos_x, pos_y;
    int          n_cmp = 0;
    int          n_err = 0;
    int          jy [24] = '{588, 577, 567, 558, 550, 543, 537, 532, 528, 525, 523, 522,
                             523, 525, 528, 532, 537, 543, 550, 558, 567, 577, 588, 600};

    move_ctr_fsm #(.STEP_DIV(DIV)) dut (
        .clk(clk), .rst(rst), .key_a(key_a), .key_d(key_d), .key_w(key_w),
        .pos_x(pos_x), .pos_y(pos_y)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic run(input int n);
        repeat (n * DIV) @(posedge clk);
        #1;
    endtask

    initial begin
        logic [11:0] prev;
        repeat (5) @(posedge clk);
        #1;
        chk("rst_x", 32'(pos_x), 512);
        chk("rst_y", 32'(pos_y), 600);
        rst = 1'b0;
        chk("rel_x", 32'(pos_x), 512);
        key_d = 1'b1;
        repeat (DIV - 1) @(posedge clk);
        #1;
        chk("pre_tick_x", 32'(pos_x), 512);
        @(posedge clk);
        #1;
        chk("first_tick_x", 32'(pos_x), 514);
        for (int t = 2; t <= 40; t++) begin
            run(1);
            chk("right_x", 32'(pos_x), 32'(512 + 2 * t));
        end
        chk("right_y", 32'(pos_y), 600);
        key_d = 1'b0;
        key_a = 1'b1;
        run(40);
        chk("left_back_x", 32'(pos_x), 512);
        key_a = 1'b0;
        key_d = 1'b1;
        run(300);
        chk("clamp_max_x", 32'(pos_x), 992);
        key_a = 1'b1;
        run(5);
        chk("both_keys_x", 32'(pos_x), 992);
        key_d = 1'b0;
        prev = pos_x;
        for (int t = 0; t < 600; t++) begin
            run(1);
            if (pos_x > prev) chk("no_wrap_x", 32'(pos_x), 32'(prev));
            prev = pos_x;
        end
        chk("clamp_min_x", 32'(pos_x), 0);
        key_a = 1'b0;
        for (int t = 1; t <= 24; t++) begin
            key_w = (t == 1) || (t >= 5 && t <= 23);
            run(1);
            chk("jump_y", 32'(pos_y), 32'(jy[t-1]));
        end
        key_w = 1'b0;
        chk("jump_x", 32'(pos_x), 0);
        run(1);
        chk("after_land_y", 32'(pos_y), 600);
        key_w = 1'b1;
        key_d = 1'b1;
        for (int t = 1; t <= 60; t++) begin
            run(1);
            chk("jr_x", 32'(pos_x), 32'(2 * t));
            chk("jr_y", 32'(pos_y), 32'(jy[(t-1)%24]));
        end
        key_w = 1'b0;
        key_d = 1'b0;
        run(11);
        chk("jr_fall_y", 32'(pos_y), 588);
        run(3);
        chk("jr_end_y", 32'(pos_y), 600);
        chk("jr_end_x", 32'(pos_x), 120);
        key_w = 1'b1;
        key_d = 1'b1;
        run(1);
        key_w = 1'b0;
        run(5);
        chk("pre_rst_y", 32'(pos_y), 543);
        chk("pre_rst_x", 32'(pos_x), 132);
        #3;
        rst = 1'b1;
        #1;
        chk("async_rst_x", 32'(pos_x), 512);
        chk("async_rst_y", 32'(pos_y), 600);
        key_d = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        run(3);
        chk("post_rst_idle_y", 32'(pos_y), 600);
        chk("post_rst_idle_x", 32'(pos_x), 512);
        key_w = 1'b1;
        run(1);
        chk("post_rst_jump_y", 32'(pos_y), 588);
        key_w = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
